// File: rtl/instruction_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder_pkg
//  Description : Opcode encodings, field positions and the decoded-field
//                struct shared by the NPU instruction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_decoder_pkg;

  localparam int INST_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int OPCODE_W   = 4;
  localparam int SRC1_MSB   = 27;
  localparam int SRC1_LSB   = 22;
  localparam int SRC2_MSB   = 21;
  localparam int SRC2_LSB   = 16;
  localparam int SRC_W      = 6;
  localparam int DEST_MSB   = 15;
  localparam int DEST_LSB   = 14;
  localparam int DEST_W     = 2;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;

  // First opcode value of the reserved block (0xC..0xF)
  localparam logic [OPCODE_W-1:0] RESERVED_BASE = 4'hC;

  typedef enum logic [OPCODE_W-1:0] {
    NOP    = 4'h0,
    LOAD   = 4'h1,
    STORE  = 4'h2,
    ADD    = 4'h3,
    SUB    = 4'h4,
    MUL    = 4'h5,
    MAC    = 4'h6,
    RELU   = 4'h7,
    MATMUL = 4'h8,
    MAX    = 4'h9,
    MOVI   = 4'hA,
    SHIFT  = 4'hB
  } opcode_t;

  typedef struct packed {
    opcode_t            opcode;
    logic [SRC_W-1:0]   src1;
    logic [SRC_W-1:0]   src2;
    logic [DEST_W-1:0]  dest;
    logic [IMM_W-1:0]   immediate;
  } decoded_inst_t;

  function automatic logic is_reserved(input opcode_t op);
    return (OPCODE_W'(op) >= RESERVED_BASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decoder_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_field_slicer
//  Description : Purely combinational split of a 32-bit instruction word into
//                its decoded fields. Dest deliberately overlaps the top two
//                immediate bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_field_slicer
  import instruction_decoder_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output decoded_inst_t     fields
);

  // Plain bit slicing; the opcode cast keeps reserved values 0xC..0xF intact
  always_comb begin
    fields           = '0;
    fields.opcode    = opcode_t'(inst[OPCODE_MSB:OPCODE_LSB]);
    fields.src1      = inst[SRC1_MSB:SRC1_LSB];
    fields.src2      = inst[SRC2_MSB:SRC2_LSB];
    fields.dest      = inst[DEST_MSB:DEST_LSB];
    fields.immediate = inst[IMM_MSB:IMM_LSB];
  end

endmodule
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder
//  Description : Registered field decoder for the NPU 32-bit instruction word.
//                Fields appear one clock after a valid instruction together
//                with dec_valid; they hold while no instruction is offered.
//  Options     : INSTR_DECODER_ILLEGAL_CHECK_EN - flag reserved opcodes
//                (0xC..0xF) on the illegal output; otherwise illegal is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_valid,
  input  logic [INST_W-1:0]   inst,
  output logic                dec_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [SRC_W-1:0]    src1,
  output logic [SRC_W-1:0]    src2,
  output logic [DEST_W-1:0]   dest,
  output logic [IMM_W-1:0]    immediate,
  output logic                illegal
);

  decoded_inst_t sliced;
  decoded_inst_t fields_reg;
  logic          valid_reg;

  inst_field_slicer u_slicer (
    .inst   (inst),
    .fields (sliced)
  );

  // Valid flag follows inst_valid; fields load only on a valid instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      fields_reg <= '0;
    end else begin
      valid_reg <= inst_valid;
      if (inst_valid) begin
        fields_reg <= sliced;
      end
    end
  end

`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
  logic illegal_reg;

  // Flag is set only by a captured reserved opcode; idle cycles clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= inst_valid && is_reserved(sliced.opcode);
    end
  end

  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  assign dec_valid = valid_reg;
  assign opcode    = OPCODE_W'(fields_reg.opcode);
  assign src1      = fields_reg.src1;
  assign src2      = fields_reg.src2;
  assign dest      = fields_reg.dest;
  assign immediate = fields_reg.immediate;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decoder
//  Description : Self-checking bench for instruction_decoder: directed
//                vectors, asynchronous reset, then randomized traffic
//                compared against a behavioural field model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        dec_valid;
  logic [3:0]  opcode;
  logic [5:0]  src1;
  logic [5:0]  src2;
  logic [1:0]  dest;
  logic [15:0] immediate;
  logic        illegal;

  int tests;
  int failed;

  // Reference model state: what the outputs should show right now
  logic        exp_valid;
  logic [31:0] exp_word;
  logic        exp_ill;

  instruction_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .dec_valid  (dec_valid),
    .opcode     (opcode),
    .src1       (src1),
    .src2       (src2),
    .dest       (dest),
    .immediate  (immediate),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected fields derived arithmetically from the last accepted word
  task automatic check_all();
    check("dec_valid", 32'(dec_valid), 32'(exp_valid));
    check("opcode",    32'(opcode),    (exp_word / 32'h1000_0000));
    check("src1",      32'(src1),      (exp_word / 32'h0040_0000) % 64);
    check("src2",      32'(src2),      (exp_word / 32'h0001_0000) % 64);
    check("dest",      32'(dest),      (exp_word % 32'h1_0000) / 32'h4000);
    check("immediate", 32'(immediate), exp_word % 32'h1_0000);
    check("illegal",   32'(illegal),   32'(exp_ill));
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_word  = 32'h0;
    exp_ill   = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [31:0] w);
    @(negedge clk);
    inst_valid = v;
    inst       = w;
    @(posedge clk);
    exp_valid = v;
    if (v) exp_word = w;
`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
    exp_ill = v && ((w / 32'h1000_0000) >= 12);
`else
    exp_ill = 1'b0;
`endif
    #1;
    check_all();
  endtask

  // Pull reset low between edges and check outputs clear without a clock
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    inst_valid = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    model_reset();
    rst_n      = 1'b0;
    inst_valid = 1'b1;
    inst       = 32'hFFFF_FFFF;
    #22;
    check_all();
    @(negedge clk);
    rst_n      = 1'b1;
    inst_valid = 1'b0;
    cycle(1'b0, 32'hDEAD_BEEF);

    cycle(1'b1, 32'h8000_0000);
    cycle(1'b1, 32'hA543_21F0);
    cycle(1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 32'h1234_5678);
    cycle(1'b0, 32'hC000_0000);

    cycle(1'b1, 32'hC123_4567);
    async_reset();
    cycle(1'b0, 32'hFFFF_FFFF);
    cycle(1'b1, 32'h0000_4000);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
      end
      cycle(1'($urandom_range(0, 3) != 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
